// File: rtl/truth_table_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner_if
// Description : Control/result bus between a requester and truth_table_scanner.
//               Optional first-fail fields exist when TTS_FIRST_FAIL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_scanner_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        match;
    logic [4:0]  mismatch_cnt;
`ifdef TTS_FIRST_FAIL_EN
    logic [3:0]  first_fail;
    logic        first_fail_vld;
`endif

    modport master (
        output start,
        input  busy, done, table_out, match, mismatch_cnt
`ifdef TTS_FIRST_FAIL_EN
        , input first_fail, first_fail_vld
`endif
    );

    modport slave (
        input  start,
        output busy, done, table_out, match, mismatch_cnt
`ifdef TTS_FIRST_FAIL_EN
        , output first_fail, first_fail_vld
`endif
    );
endinterface
`default_nettype wire

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner
// Description : Sweeps {a,b,c,d} through 0..15, captures f_in into a truth
//               table and compares it with EXPECTED. Optional macro
//               TTS_FIRST_FAIL_EN adds first-mismatch code reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_scanner #(
    parameter int          SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'h00BD
) (
    input  wire logic clk,
    input  wire logic rst_b,
    input  wire logic f_in,
    output logic      a,
    output logic      b,
    output logic      c,
    output logic      d,
    truth_table_scanner_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_SETTLE_M1 = 8'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  code_q,  code_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  mm_q,    mm_d;
    logic        match_q, match_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
`ifdef TTS_FIRST_FAIL_EN
    logic [3:0]  ff_q,    ff_d;
    logic        ffv_q,   ffv_d;
`endif

    logic w_sample;
    logic w_miss;

    assign w_sample = (cnt_q == c_SETTLE_M1);
    assign w_miss   = (f_in != EXPECTED[code_q]);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            code_q  <= 4'd0;
            cnt_q   <= 8'd0;
            table_q <= 16'd0;
            mm_q    <= 5'd0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TTS_FIRST_FAIL_EN
            ff_q    <= 4'd0;
            ffv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            mm_q    <= mm_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef TTS_FIRST_FAIL_EN
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        mm_d    = mm_q;
        match_d = match_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef TTS_FIRST_FAIL_EN
        ff_d    = ff_q;
        ffv_d   = ffv_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    code_d  = 4'd0;
                    cnt_d   = 8'd0;
                    table_d = 16'd0;
                    mm_d    = 5'd0;
                    match_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef TTS_FIRST_FAIL_EN
                    ff_d    = 4'd0;
                    ffv_d   = 1'b0;
`endif
                end
            end
            SCAN: begin
                if (w_sample) begin
                    table_d[code_q] = f_in;
                    cnt_d           = 8'd0;
                    if (w_miss) begin
                        mm_d = mm_q + 5'd1;
`ifdef TTS_FIRST_FAIL_EN
                        if (!ffv_q) begin
                            ff_d  = code_q;
                            ffv_d = 1'b1;
                        end
`endif
                    end
                    if (code_q != 4'd15) begin
                        code_d = code_q + 4'd1;
                    end else begin
                        // Compare against the table including the bit just captured.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        match_d = (table_d == EXPECTED);
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {a, b, c, d}     = code_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.table_out    = table_q;
    assign bus.match        = match_q;
    assign bus.mismatch_cnt = mm_q;
`ifdef TTS_FIRST_FAIL_EN
    assign bus.first_fail     = ff_q;
    assign bus.first_fail_vld = ffv_q;
`endif

endmodule
`default_nettype wire
